// File: rtl/rvv_vector_mem_responder.sv
// Line-wide backing-memory responder: accepts one full-line read or write at a time
// and completes it with a one-cycle mem_ready pulse LATENCY cycles after acceptance.
module rvv_vector_mem_responder #(
    parameter int unsigned ADDRESS_SIZE     = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 512,
    parameter int unsigned MEM_LINES        = 1024,
    parameter int unsigned LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_read_en,
    input  logic                        mem_write_en,
    input  logic [ADDRESS_SIZE-1:0]     mem_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_write_data,
    output logic                        mem_ready,
    output logic [CACHE_LINE_WIDTH-1:0] mem_read_data,
    output logic                        busy,
    output logic                        addr_err,
    output logic                        proto_err
);

    localparam int unsigned OFFSET_W = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int unsigned IDX_W    = $clog2(MEM_LINES);
    localparam int unsigned LINE_W   = ADDRESS_SIZE - OFFSET_W;
    localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            line_q;
    logic                        oor_q;
    logic                        wr_q;
    logic [CACHE_LINE_WIDTH-1:0] wdata_q;
    logic [CACHE_LINE_WIDTH-1:0] mem_array [MEM_LINES];

    logic              accept;
    logic              commit;
    logic [LINE_W-1:0] line_full;
    logic              oor_c;
    logic              unused_offset_bits;

    // Byte offset within the line never selects anything.
    assign unused_offset_bits = ^mem_addr[OFFSET_W-1:0];

    assign line_full = mem_addr[ADDRESS_SIZE-1:OFFSET_W];
    assign oor_c     = (line_full >> IDX_W) != LINE_W'(0);

    // Next-state logic; commit marks the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read_en || mem_write_en) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(0)) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            line_q        <= '0;
            oor_q         <= 1'b0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            mem_ready     <= 1'b0;
            busy          <= 1'b0;
            addr_err      <= 1'b0;
            proto_err     <= 1'b0;
            mem_read_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_ready <= commit;
            busy      <= (state_d != IDLE);
            addr_err  <= commit & oor_q;
            proto_err <= accept & mem_read_en & mem_write_en;
            if (accept) begin
                line_q  <= line_full[IDX_W-1:0];
                oor_q   <= oor_c;
                wr_q    <= mem_write_en;
                wdata_q <= mem_write_data;
            end
            if (commit && !wr_q) begin
                mem_read_data <= oor_q ? '0 : mem_array[line_q];
            end
        end
    end

    // Line storage is never cleared; an aborted op never reaches this write.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q && !oor_q) begin
            mem_array[line_q] <= wdata_q;
        end
    end

endmodule
